fu_wb_arbiter: RTL and testbench
================================

# fu_wb_arbiter

Parametrised writeback arbiter that replaces the fixed per-port result muxing in the execute stage. It collects results from `NumFu` functional-unit channels, each through its own small FIFO. Every cycle it grants up to `NumWbPorts` non-empty channels onto the scoreboard writeback ports, using round-robin or fixed-priority arbitration. It sits between the FUs (ALU/BJU/CSR/MDU/LSU) and the scoreboard, and adds per-channel buffering, backpressure and flush support, none of which the current single-mux scheme has.

## Interface
Parameters:
- `NumFu`, 4: number of FU result channels (≥1).
- `NumWbPorts`, 2: number of writeback ports (1..`NumFu`).
- `FifoDepth`, 2: entries per channel FIFO (power of two, ≥2).
- `DataWidth`, 32: result data width.
- `IdxWidth`, `ScoreboardIndex`: scoreboard index width.
- `ArbMode`, 0: 0 = round-robin, 1 = fixed priority (lowest channel index first).

Ports:
- `clock`  input  1  sole clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-low reset (state reset when `reset==0` at posedge).
- `flush`  input  1  discard all buffered and incoming results.
- `fu_valid`  input  `NumFu`  per-channel result valid.
- `fu_ready`  output  `NumFu`  per-channel accept.
- `fu_result`  input  `NumFu` × `fu_result_t`  per-channel {data, idx}.
- `wb`  output  `NumWbPorts` × `writeback_t`  writeback ports {valid, data, idx}; no backpressure, scoreboard always accepts.
- `fifo_empty`  output  `NumFu`  per-channel empty flag (debug/perf).

## Operation
- Push: channel i accepts when `fu_valid[i] & fu_ready[i]` and `flush==0`.
- `fu_ready[i] = (count[i] < FifoDepth) & reset & ~flush`.
  - Depends only on registered state plus `reset`/`flush`; no combinational path from the grant logic.
- Ordering: each channel FIFO preserves its own order. Across channels no ordering is guaranteed; the scoreboard idx disambiguates.
- Arbitration scans channels circularly, starting at `rr_ptr` (ArbMode 0) or at 0 (ArbMode 1).
  - Port k is granted the (k+1)-th non-empty channel found in scan order.
  - Ports with no candidate drive `valid=0`, `data=0`, `idx=0`.
- `wb[k]` is driven combinationally from the head entry of its granted FIFO. Every granted head pops at the clock edge.
- `rr_ptr` update:
  - If any grant occurs, it becomes (index of the last granted channel + 1) mod `NumFu`.
  - Otherwise it holds.
  - It is unused in ArbMode 1.
- Flush cycle:
  - All `wb[k].valid` are forced to 0.
  - All counts and read/write pointers clear at the edge.
  - Any input presented that cycle is dropped.
  - `rr_ptr` holds its value.
- Simultaneous push and pop on the same channel is legal whenever `count<FifoDepth`; count is unchanged.
  - A full channel cannot push; it must pop first, and `fu_ready` rises the next cycle.
- Pointer/count arithmetic: `$clog2(FifoDepth)`-bit pointers wrap naturally. Count is `$clog2(FifoDepth)+1` bits.

## Timing
- Latency: a result accepted at edge t appears on a wb port during cycle t+1 at the earliest. There is no bypass path.
- Throughput: up to `NumWbPorts` results per cycle in aggregate, and one per channel per cycle.
- Reset (while `reset==0`):
  - `fu_ready=0`, all `wb[k].valid=0`, `fifo_empty` all ones.
  - Counts and pointers clear; `rr_ptr=0`.
- Mid-operation reset discards all buffered results, exactly as flush does, and also clears `rr_ptr`.
- The first cycle after reset release has `fu_ready` all ones.

## Structure
- `OoO_pkg` gains:
  - `fu_result_t` = {data[DataWidth], idx[IdxWidth]};
  - `arb_mode_e` {ARB_RR, ARB_FIXED}.
- It reuses the existing `writeback_t` and `ScoreboardIndex`.
- Sub-module `wb_fifo`: a synchronous FIFO with push, pop, flush, count, empty, full and head outputs, instantiated `NumFu` times.
- The arbiter scan is a combinational loop in the top module.
- `ex_stage` instantiates `fu_wb_arbiter` with `NumFu=4`, `NumWbPorts=WriteBackPorts`.

## Test plan
All scenarios use `NumFu=4`, `NumWbPorts=2`, `FifoDepth=2` unless noted.
- Reset: hold `reset=0` for 2 cycles with `fu_valid=4'b1111` -> `fu_ready=0`, all `wb.valid=0`. After release -> `fu_ready=4'b1111`, `fifo_empty=4'b1111`, no writeback.
- Single result: ch2 pushes data 0xDEADBEEF, idx 5 at edge t -> in cycle t+1 `wb[0]`={1, 0xDEADBEEF, 5}, `wb[1].valid=0`; next `rr_ptr=3`.
- Full load: all 4 channels push one result each at edge t with `rr_ptr=0` -> cycle t+1 grants ch0 (port 0) and ch1 (port 1); cycle t+2 grants ch2 and ch3; `rr_ptr` returns to 0.
- Backpressure: all channels push every cycle with incrementing data -> FIFOs fill and `fu_ready` toggles per channel. Check no result is lost or duplicated, each channel's data stays in order, and over 100 cycles each channel gets within ±1 grant of the others.
- Flush: with 2 entries in ch0 and 1 in ch3, assert `flush` for 1 cycle while ch1 pushes -> no `wb.valid` in that cycle. Next cycle `fifo_empty=4'b1111`, `fu_ready=4'b1111`, `rr_ptr` unchanged, and ch1's result never appears.
- Fixed priority (`ArbMode=1`, `NumWbPorts=1`): ch0 and ch3 are continuously valid -> `wb[0]` always carries ch0 while ch0 is non-empty, and ch3 drains only when ch0 is empty.

Source files
------------

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the execute-stage writeback arbiter.
//   ScoreboardIndex : width of a scoreboard entry index
//   XLEN            : default result data width
//   fu_result_t     : {data, idx} produced by a functional unit
//   writeback_t     : {valid, data, idx} presented to the scoreboard
//   arb_mode_e      : round-robin or fixed-priority channel selection
//   wrap_next       : circular successor of a channel index
package fu_wb_arbiter_pkg;

    localparam int ScoreboardIndex = 4;
    localparam int XLEN            = 32;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic [XLEN-1:0]            data;
        logic [ScoreboardIndex-1:0] idx;
    } fu_result_t;

    typedef struct packed {
        logic                       valid;
        logic [XLEN-1:0]            data;
        logic [ScoreboardIndex-1:0] idx;
    } writeback_t;

    function automatic int wrap_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_fifo.sv
// Per-channel result buffer for the writeback arbiter.
//   clock  : posedge clock
//   reset  : synchronous active-low reset
//   flush  : clears pointers and count at the edge
//   push   : write din (ignored when full)
//   pop    : drop head entry (ignored when empty)
//   din    : entry to write
//   head   : oldest entry, valid when !empty
//   count  : number of stored entries
//   empty  : count == 0
//   full   : count == Depth
module wb_fifo
    import fu_wb_arbiter_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = XLEN + ScoreboardIndex
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         head,
    output logic [$clog2(Depth):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] DepthC = (AW + 1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers decide what is live.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == DepthC);

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter between the functional units and the scoreboard.
// Each FU channel is buffered in its own wb_fifo; every cycle up to
// NumWbPorts non-empty channels are granted, scanning circularly from the
// round-robin pointer (ArbMode 0) or from channel 0 (ArbMode 1).
//   clock      : posedge clock
//   reset      : synchronous active-low reset
//   flush      : drop all buffered and incoming results
//   fu_valid   : per-channel result valid
//   fu_ready   : per-channel accept (registered state + reset/flush only)
//   fu_result  : per-channel {data, idx}
//   wb         : per-port {valid, data, idx}, scoreboard always accepts
//   fifo_empty : per-channel empty flag
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int NumFu      = 4,
    parameter int NumWbPorts = 2,
    parameter int FifoDepth  = 2,
    parameter int DataWidth  = XLEN,
    parameter int IdxWidth   = ScoreboardIndex,
    parameter int ArbMode    = 0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [NumFu-1:0]                              fu_valid,
    output logic [NumFu-1:0]                              fu_ready,
    input  logic [NumFu-1:0][DataWidth+IdxWidth-1:0]      fu_result,
    output logic [NumWbPorts-1:0][DataWidth+IdxWidth:0]   wb,
    output logic [NumFu-1:0]                              fifo_empty
);

    localparam int ResW = DataWidth + IdxWidth;
    localparam int CntW = $clog2(FifoDepth) + 1;
    localparam int PtrW = (NumFu > 1) ? $clog2(NumFu) : 1;
    localparam arb_mode_e Mode = (ArbMode == 1) ? ARB_FIXED : ARB_RR;
    localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);

    logic [NumFu-1:0]                 w_empty;
    logic [NumFu-1:0]                 w_full;
    logic [NumFu-1:0]                 w_ready;
    logic [NumFu-1:0]                 w_push;
    logic [NumFu-1:0]                 w_pop;
    logic [NumFu-1:0][CntW-1:0]       w_count;
    logic [NumFu-1:0][ResW-1:0]       w_head;
    logic                             w_arb_en;
    logic [NumWbPorts-1:0]            w_port_vld;
    logic [NumWbPorts-1:0][PtrW-1:0]  w_port_ch;
    logic                             w_any_grant;
    logic [PtrW-1:0]                  w_next_rr;
    logic [PtrW-1:0]                  r_rr_ptr;

    // Ready looks only at stored occupancy, never at this cycle's grants,
    // so a full channel must drain one cycle before it accepts again.
    always_comb begin
        for (int i = 0; i < NumFu; i++) begin
            w_ready[i] = (w_count[i] < DepthC) & reset & ~flush;
        end
    end

    assign w_push     = fu_valid & w_ready & ~w_full;
    assign fu_ready   = w_ready;
    assign fifo_empty = w_empty | {NumFu{~reset}};
    assign w_arb_en   = reset & ~flush;

    for (genvar g = 0; g < NumFu; g++) begin : g_fifo
        wb_fifo #(
            .Depth (FifoDepth),
            .Width (ResW)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (fu_result[g]),
            .head  (w_head[g]),
            .count (w_count[g]),
            .empty (w_empty[g]),
            .full  (w_full[g])
        );
    end

    // Port k takes the (k+1)-th non-empty channel met in circular scan order.
    always_comb begin
        int ch;
        int n;
        int start;
        w_pop       = '0;
        w_port_vld  = '0;
        w_port_ch   = '0;
        w_any_grant = 1'b0;
        w_next_rr   = r_rr_ptr;
        n           = 0;
        start       = (Mode == ARB_FIXED) ? 0 : int'(r_rr_ptr);
        for (int s = 0; s < NumFu; s++) begin
            ch = start + s;
            if (ch >= NumFu) ch = ch - NumFu;
            if (w_arb_en && !w_empty[ch] && (n < NumWbPorts)) begin
                w_pop[ch]     = 1'b1;
                w_port_vld[n] = 1'b1;
                w_port_ch[n]  = PtrW'(ch);
                w_any_grant   = 1'b1;
                w_next_rr     = PtrW'(wrap_next(ch, NumFu));
                n             = n + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NumWbPorts; k++) begin
            wb[k] = w_port_vld[k] ? {1'b1, w_head[w_port_ch[k]]} : '0;
        end
    end

    // Flush suppresses grants, so the pointer holds; only reset clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_any_grant) begin
            r_rr_ptr <= w_next_rr;
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: a round-robin 4x2 instance and a fixed-priority
// 4x1 instance run side by side against a queue-based reference model.
module tb_fu_wb_arbiter;
    import fu_wb_arbiter_pkg::*;

    localparam int DW = XLEN;
    localparam int IW = ScoreboardIndex;
    localparam int RW = DW + IW;
    localparam int WW = RW + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset;
    logic                 flush0, flush1;
    logic [3:0]           val0, val1, rdy0, rdy1, emp0, emp1;
    logic [3:0][RW-1:0]   res0, res1;
    logic [1:0][WW-1:0]   wb0;
    logic [0:0][WW-1:0]   wb1;

    fu_wb_arbiter #(.NumFu(4), .NumWbPorts(2), .FifoDepth(2),
                    .DataWidth(DW), .IdxWidth(IW), .ArbMode(0)) dut_rr (
        .clock(clock), .reset(reset), .flush(flush0), .fu_valid(val0),
        .fu_ready(rdy0), .fu_result(res0), .wb(wb0), .fifo_empty(emp0));

    fu_wb_arbiter #(.NumFu(4), .NumWbPorts(1), .FifoDepth(2),
                    .DataWidth(DW), .IdxWidth(IW), .ArbMode(1)) dut_fix (
        .clock(clock), .reset(reset), .flush(flush1), .fu_valid(val1),
        .fu_ready(rdy1), .fu_result(res1), .wb(wb1), .fifo_empty(emp1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per channel, a scan pointer per unit.
    logic [RW-1:0] mq [2][4][$];
    int            mrr [2];
    logic [3:0]    e_rdy [2];
    logic [3:0]    e_emp [2];
    logic [WW-1:0] e_wb  [2][2];

    logic [3:0]    s_rdy0, s_emp0, s_rdy1, s_emp1;
    logic [WW-1:0] s_wb0_0, s_wb0_1, s_wb1;

    task automatic model_step(input int u, input logic rst_n, input logic fl,
                              input logic [3:0] v, input logic [3:0][RW-1:0] r);
        int np, start, n, last, ch;
        np = (u == 0) ? 2 : 1;
        e_wb[u][0] = '0;
        e_wb[u][1] = '0;
        if (!rst_n) begin
            e_rdy[u] = 4'h0;
            e_emp[u] = 4'hF;
            for (int i = 0; i < 4; i++) mq[u][i].delete();
            mrr[u] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            e_rdy[u][i] = (mq[u][i].size() < 2) && !fl;
            e_emp[u][i] = (mq[u][i].size() == 0);
        end
        if (fl) begin
            for (int i = 0; i < 4; i++) mq[u][i].delete();
            return;
        end
        start = (u == 0) ? mrr[u] : 0;
        n = 0;
        last = -1;
        for (int s = 0; s < 4; s++) begin
            ch = (start + s) % 4;
            if (mq[u][ch].size() > 0 && n < np) begin
                e_wb[u][n] = {1'b1, mq[u][ch].pop_front()};
                n++;
                last = ch;
            end
        end
        if (last >= 0) mrr[u] = (last + 1) % 4;
        for (int i = 0; i < 4; i++)
            if (v[i] && e_rdy[u][i]) mq[u][i].push_back(r[i]);
    endtask

    task automatic cycle();
        @(negedge clock);
        s_rdy0 = rdy0;  s_emp0 = emp0;  s_wb0_0 = wb0[0];  s_wb0_1 = wb0[1];
        s_rdy1 = rdy1;  s_emp1 = emp1;  s_wb1 = wb1[0];
        model_step(0, reset, flush0, val0, res0);
        model_step(1, reset, flush1, val1, res1);
        check("rr.ready", 64'(s_rdy0), 64'(e_rdy[0]));
        check("rr.empty", 64'(s_emp0), 64'(e_emp[0]));
        check("rr.wb0",   64'(s_wb0_0), 64'(e_wb[0][0]));
        check("rr.wb1",   64'(s_wb0_1), 64'(e_wb[0][1]));
        check("fix.ready", 64'(s_rdy1), 64'(e_rdy[1]));
        check("fix.empty", 64'(s_emp1), 64'(e_emp[1]));
        check("fix.wb0",   64'(s_wb1),  64'(e_wb[1][0]));
        @(posedge clock);
        #1;
    endtask

    function automatic logic [RW-1:0] mk(input logic [31:0] d, input logic [3:0] idx);
        fu_result_t t;
        t.data = d;
        t.idx  = idx;
        return t;
    endfunction

    int          cnt0 [4];
    int          cnt1 [4];
    int          gcnt [4];
    int          gmax, gmin, c;
    logic        pre_ch0_empty;

    initial begin
        reset = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        val0 = 4'hF; val1 = 4'hF; res0 = '0; res1 = '0;
        mrr[0] = 0; mrr[1] = 0;
        for (int i = 0; i < 4; i++) begin cnt0[i] = 0; cnt1[i] = 0; gcnt[i] = 0; end
        @(posedge clock);
        #1;

        // Reset held with all channels valid.
        repeat (2) begin
            cycle();
            check("rst.ready", 64'(s_rdy0), 64'(4'h0));
            check("rst.wbv",   64'({s_wb0_0[WW-1], s_wb0_1[WW-1]}), 64'(2'b00));
        end
        reset = 1'b1; val0 = 4'h0; val1 = 4'h0;
        cycle();
        check("rel.ready", 64'(s_rdy0), 64'(4'hF));
        check("rel.empty", 64'(s_emp0), 64'(4'hF));

        // Single result on ch2.
        val0 = 4'b0100; res0[2] = mk(32'hDEADBEEF, 4'd5);
        cycle();
        val0 = 4'h0;
        cycle();
        check("single.wb0", 64'(s_wb0_0), 64'({1'b1, 32'hDEADBEEF, 4'd5}));
        check("single.wb1v", 64'(s_wb0_1[WW-1]), 64'(1'b0));

        // Pointer now 3: ch3 must beat ch1.
        val0 = 4'b1010; res0[1] = mk(32'h11, 4'd1); res0[3] = mk(32'h33, 4'd3);
        cycle();
        val0 = 4'h0;
        cycle();
        check("rr3.port0", 64'(s_wb0_0), 64'({1'b1, 32'h33, 4'd3}));
        check("rr3.port1", 64'(s_wb0_1), 64'({1'b1, 32'h11, 4'd1}));
        val0 = 4'b1000; res0[3] = mk(32'h34, 4'd3);
        cycle();
        val0 = 4'h0;
        cycle();

        // Full load from pointer 0.
        val0 = 4'hF;
        for (int i = 0; i < 4; i++) res0[i] = mk(32'hA0 + 32'(i), 4'(i));
        cycle();
        val0 = 4'h0;
        cycle();
        check("full.t1p0", 64'(s_wb0_0[RW-1:IW]), 64'(32'hA0));
        check("full.t1p1", 64'(s_wb0_1[RW-1:IW]), 64'(32'hA1));
        cycle();
        check("full.t2p0", 64'(s_wb0_0[RW-1:IW]), 64'(32'hA2));
        check("full.t2p1", 64'(s_wb0_1[RW-1:IW]), 64'(32'hA3));
        val0 = 4'b1001; res0[0] = mk(32'hC0, 4'd0); res0[3] = mk(32'hC3, 4'd3);
        cycle();
        val0 = 4'h0;
        cycle();
        check("full.rr0", 64'(s_wb0_0[RW-1:IW]), 64'(32'hC0));

        // Saturating load; fixed-priority unit sees ch0 and ch3 only.
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        for (int t = 0; t < 120; t++) begin
            val0 = 4'hF;
            val1 = (t < 100) ? 4'b1001 : 4'b1000;
            for (int i = 0; i < 4; i++) begin
                res0[i] = {4'(i), 28'(cnt0[i]), 4'(i)};
                res1[i] = {4'(i), 28'(cnt1[i]), 4'(i)};
            end
            pre_ch0_empty = (mq[1][0].size() == 0);
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (val0[i] && e_rdy[0][i]) cnt0[i]++;
                if (val1[i] && e_rdy[1][i]) cnt1[i]++;
            end
            if (t >= 10 && t < 110) begin
                c = int'(s_wb0_0[RW-1 -: 4]);
                if (s_wb0_0[WW-1] && c < 4) gcnt[c]++;
                c = int'(s_wb0_1[RW-1 -: 4]);
                if (s_wb0_1[WW-1] && c < 4) gcnt[c]++;
            end
            if (s_wb1[WW-1])
                check("fix.chan", 64'(s_wb1[RW-1 -: 4]), 64'(pre_ch0_empty ? 4'd3 : 4'd0));
        end
        gmax = gcnt[0]; gmin = gcnt[0];
        for (int i = 1; i < 4; i++) begin
            if (gcnt[i] > gmax) gmax = gcnt[i];
            if (gcnt[i] < gmin) gmin = gcnt[i];
        end
        check("fair.spread_le1", 64'(gmax - gmin <= 1), 64'(1));
        check("fair.total", 64'(gmax + gmin > 80), 64'(1));

        // Flush with buffered entries while ch1 pushes.
        val0 = 4'b1111;
        cycle();
        val0 = 4'b0010; res0[1] = mk(32'hF1F1F1F1, 4'd9); flush0 = 1'b1;
        cycle();
        check("flush.wbv", 64'({s_wb0_0[WW-1], s_wb0_1[WW-1]}), 64'(2'b00));
        val0 = 4'h0; flush0 = 1'b0;
        cycle();
        check("flush.empty", 64'(s_emp0), 64'(4'hF));
        check("flush.ready", 64'(s_rdy0), 64'(4'hF));
        repeat (3) cycle();

        // Randomized traffic, occasional flush and reset.
        for (int t = 0; t < 400; t++) begin
            reset  = ($urandom_range(99) != 0);
            flush0 = ($urandom_range(19) == 0);
            flush1 = ($urandom_range(19) == 0);
            val0   = 4'($urandom);
            val1   = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                res0[i] = mk($urandom, 4'($urandom));
                res1[i] = mk($urandom, 4'($urandom));
            end
            cycle();
        end
        reset = 1'b1; flush0 = 1'b0; flush1 = 1'b0; val0 = 4'h0; val1 = 4'h0;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
